// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   Port 0 = fetch/branch unit, port 1 = execute stage. Round-robin grant in
//   IDLE, operands registered into the ALU (ISSUE), result/flags held in a
//   response register (HOLD) until the owning requester accepts it.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   reqN_valid/ready/num1/num2/op    request handshake + payload (N = 0, 1)
//   respN_valid/ready                response handshake (N = 0, 1)
//   respN_result/overflow/invalid    shared response register contents
//   alu_num1/num2/op                 operand registers to the external ALU
//   alu_result/overflow/op_invalid   combinational ALU outputs
//   busy                             high whenever not in IDLE
module alu_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_num1,
    input  logic [WIDTH-1:0] req0_num2,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_num1,
    input  logic [WIDTH-1:0] req1_num2,
    input  logic [OPW-1:0]   req1_op,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_result,
    output logic             resp0_overflow,
    output logic             resp0_invalid,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_result,
    output logic             resp1_overflow,
    output logic             resp1_invalid,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    input  logic             alu_op_invalid,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] num1_q, num1_d;
    logic [WIDTH-1:0] num2_q, num2_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             inv_q, inv_d;

    logic             grant_vld_c;
    logic             grant_id_c;
    logic             owner_ready_c;

    // Round-robin grant; on a tie the requester that did not win last time wins.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_id_c  = 1'b0;
        if (state_q == IDLE) begin
            grant_vld_c = req0_valid | req1_valid;
            if (req0_valid && req1_valid) begin
                grant_id_c = ~last_q;
            end else begin
                grant_id_c = req1_valid;
            end
        end
    end

    assign owner_ready_c = owner_q ? resp1_ready : resp0_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld_c) state_d = ISSUE;
            ISSUE:   state_d = HOLD;
            HOLD:    if (owner_ready_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture on accept, response capture in ISSUE; otherwise hold.
    always_comb begin
        last_d   = last_q;
        owner_d  = owner_q;
        num1_d   = num1_q;
        num2_d   = num2_q;
        op_d     = op_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        inv_d    = inv_q;
        if (grant_vld_c) begin
            owner_d = grant_id_c;
            last_d  = grant_id_c;
            num1_d  = grant_id_c ? req1_num1 : req0_num1;
            num2_d  = grant_id_c ? req1_num2 : req0_num2;
            op_d    = grant_id_c ? req1_op   : req0_op;
        end
        if (state_q == ISSUE) begin
            result_d = alu_result;
            ovf_d    = alu_overflow;
            inv_d    = alu_op_invalid;
        end
    end

    // Datapath registers; last resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            num1_q   <= '0;
            num2_q   <= '0;
            op_q     <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            last_q   <= last_d;
            owner_q  <= owner_d;
            num1_q   <= num1_d;
            num2_q   <= num2_d;
            op_q     <= op_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            inv_q    <= inv_d;
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        req0_ready     = grant_vld_c & ~grant_id_c;
        req1_ready     = grant_vld_c &  grant_id_c;
        resp0_valid    = (state_q == HOLD) & ~owner_q;
        resp1_valid    = (state_q == HOLD) &  owner_q;
        busy           = (state_q != IDLE);
        alu_num1       = num1_q;
        alu_num2       = num2_q;
        alu_op         = op_q;
        resp0_result   = result_q;
        resp0_overflow = ovf_q;
        resp0_invalid  = inv_q;
        resp1_result   = result_q;
        resp1_overflow = ovf_q;
        resp1_invalid  = inv_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a stand-in ALU.
module tb_alu_arbiter;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned OPW   = 5;
    localparam logic [OPW-1:0] OP_ADD = 5'd0;
    localparam logic [OPW-1:0] OP_SUB = 5'd1;
    localparam logic [OPW-1:0] OP_AND = 5'd2;
    localparam logic [OPW-1:0] OP_OR  = 5'd3;
    localparam logic [OPW-1:0] OP_XOR = 5'd4;
    localparam logic [OPW-1:0] OP_BAD = 5'h1F;

    logic             clk, rst_n;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_num1, req0_num2, req1_num1, req1_num2;
    logic [OPW-1:0]   req0_op, req1_op;
    logic             resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [WIDTH-1:0] resp0_result, resp1_result;
    logic             resp0_overflow, resp0_invalid, resp1_overflow, resp1_invalid;
    logic [WIDTH-1:0] alu_num1, alu_num2, alu_result;
    logic [OPW-1:0]   alu_op;
    logic             alu_overflow, alu_op_invalid, busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [WIDTH+1:0] q0[$];
    logic [WIDTH+1:0] q1[$];
    int               log_port[$];
    int               log_cyc[$];

    bit m_busy, m_last, m_owner;
    int m_age;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_num1(req0_num1), .req0_num2(req0_num2), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_num1(req1_num1), .req1_num2(req1_num2), .req1_op(req1_op),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_result(resp0_result), .resp0_overflow(resp0_overflow),
        .resp0_invalid(resp0_invalid),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_result(resp1_result), .resp1_overflow(resp1_overflow),
        .resp1_invalid(resp1_invalid),
        .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .alu_op_invalid(alu_op_invalid),
        .busy(busy)
    );

    // Reference ALU: {overflow, invalid, result}; overflow = carry/borrow out.
    function automatic logic [WIDTH+1:0] ref_alu(input logic [OPW-1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] wide;
        wide = {1'b0, a} + {1'b0, b};
        case (op)
            OP_ADD:  ref_alu = {wide[WIDTH], 1'b0, wide[WIDTH-1:0]};
            OP_SUB:  ref_alu = {(a < b), 1'b0, a - b};
            OP_AND:  ref_alu = {2'b00, a & b};
            OP_OR:   ref_alu = {2'b00, a | b};
            OP_XOR:  ref_alu = {2'b00, a ^ b};
            default: ref_alu = {2'b01, {WIDTH{1'b0}}};
        endcase
    endfunction

    always_comb {alu_overflow, alu_op_invalid, alu_result} = ref_alu(alu_op, alu_num1, alu_num2);

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Arbitration/timing model: a free block grants the only valid requester,
    // or on a tie the one that did not win last; the winner's result is shown
    // two cycles after acceptance and the block frees after it is taken.
    always @(negedge clk) begin
        bit e0, e1, ev0, ev1;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_last = 1'b1;
            m_owner = 1'b0;
            m_age  = 0;
            q0.delete();
            q1.delete();
        end else begin
            e0 = 1'b0; e1 = 1'b0; ev0 = 1'b0; ev1 = 1'b0;
            if (m_busy) m_age++;
            if (!m_busy) begin
                if (req0_valid && req1_valid) begin
                    e0 = m_last;
                    e1 = !m_last;
                end else begin
                    e0 = req0_valid;
                    e1 = req1_valid;
                end
            end else if (m_age >= 2) begin
                ev0 = !m_owner;
                ev1 = m_owner;
            end
            check("req_ready", 64'({req1_ready, req0_ready}), 64'({e1, e0}));
            check("busy", 64'(busy), 64'(m_busy));
            check("resp_valid", 64'({resp1_valid, resp0_valid}), 64'({ev1, ev0}));
            if (req0_valid && req0_ready) begin log_port.push_back(0); log_cyc.push_back(cyc); end
            if (req1_valid && req1_ready) begin log_port.push_back(1); log_cyc.push_back(cyc); end
            if (!m_busy && (e0 || e1)) begin
                m_busy  = 1'b1;
                m_owner = e1;
                m_last  = e1;
                m_age   = 0;
                if (e0) q0.push_back(ref_alu(req0_op, req0_num1, req0_num2));
                else    q1.push_back(ref_alu(req1_op, req1_num1, req1_num2));
            end else if (m_busy && m_age >= 2 && (m_owner ? resp1_ready : resp0_ready)) begin
                m_busy = 1'b0;
            end
        end
    end

    // Response monitor: compares presented results against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (resp0_valid) begin
                check("resp0_expected", 64'(q0.size() != 0), 64'(1));
                if (q0.size() != 0) begin
                    check("resp0_payload", 64'({resp0_overflow, resp0_invalid, resp0_result}), 64'(q0[0]));
                    if (resp0_ready) void'(q0.pop_front());
                end
            end
            if (resp1_valid) begin
                check("resp1_expected", 64'(q1.size() != 0), 64'(1));
                if (q1.size() != 0) begin
                    check("resp1_payload", 64'({resp1_overflow, resp1_invalid, resp1_result}), 64'(q1[0]));
                    if (resp1_ready) void'(q1.pop_front());
                end
            end
        end
    end

    function automatic logic [OPW-1:0] rand_op();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 8) return OP_BAD;
        if (r == 9) return OP_ADD;
        return OPW'(r);
    endfunction

    function automatic logic [WIDTH-1:0] rand_opnd();
        int unsigned r;
        r = $urandom_range(0, 7);
        if (r < 2) return {WIDTH{1'b1}};
        if (r == 2) return '0;
        return WIDTH'($urandom);
    endfunction

    // Called in the drive phase; returns in the drive phase of the cycle after acceptance.
    task automatic issue(input bit port, input logic [OPW-1:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit done;
        done = 1'b0;
        if (!port) begin req0_valid = 1'b1; req0_op = op; req0_num1 = a; req0_num2 = b; end
        else       begin req1_valid = 1'b1; req1_op = op; req1_num1 = a; req1_num2 = b; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (port ? req1_ready : req0_ready) done = 1'b1;
            @(posedge clk); #1;
            if (done) break;
        end
        if (!port) req0_valid = 1'b0; else req1_valid = 1'b0;
        check("issue_accepted", 64'(done), 64'(1));
    endtask

    initial begin
        bit done, hs0, hs1;
        int nlog;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_num1 = '0; req0_num2 = '0; req0_op = '0;
        req1_num1 = '0; req1_num2 = '0; req1_op = '0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_resp_valid", 64'({resp1_valid, resp0_valid}), 64'(0));
        check("rst_alu_operands", 64'({alu_op, alu_num1[15:0], alu_num2[15:0]}), 64'(0));
        check("rst_resp_result", 64'(resp0_result), 64'(0));
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Port 0 ADD 5+3.
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        issue(1'b0, OP_ADD, 32'd5, 32'd3);
        @(negedge clk); @(negedge clk);
        check("add_resp0_valid", 64'(resp0_valid), 64'(1));
        check("add_resp0_result", 64'(resp0_result), 64'(8));
        check("add_resp0_flags", 64'({resp0_overflow, resp0_invalid}), 64'(0));
        check("add_resp1_valid", 64'(resp1_valid), 64'(0));
        @(posedge clk); #1;

        // Port 1 carry out.
        issue(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk); @(negedge clk);
        check("ovf_resp1_valid", 64'(resp1_valid), 64'(1));
        check("ovf_resp1_result", 64'(resp1_result), 64'(0));
        check("ovf_resp1_overflow", 64'(resp1_overflow), 64'(1));
        @(posedge clk); #1;

        // Both ports continuously valid: alternate grants, 3 cycles apart.
        log_port.delete(); log_cyc.delete();
        req0_valid = 1'b1; req0_op = OP_ADD; req0_num1 = 32'd10; req0_num2 = 32'd20;
        req1_valid = 1'b1; req1_op = OP_SUB; req1_num1 = 32'd7;  req1_num2 = 32'd9;
        repeat (12) begin @(posedge clk); #1; end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr_grant_count", 64'(log_port.size()), 64'(4));
        nlog = (log_port.size() < 4) ? log_port.size() : 4;
        for (int i = 0; i < nlog; i++) begin
            check("rr_order", 64'(log_port[i]), 64'(i % 2));
            if (i > 0) check("rr_spacing", 64'(log_cyc[i] - log_cyc[i-1]), 64'(3));
        end
        repeat (4) begin @(posedge clk); #1; end

        // Held response blocks the other requester.
        resp0_ready = 1'b0;
        issue(1'b0, OP_XOR, 32'hF0F0_1234, 32'h0FF0_0034);
        req1_valid = 1'b1; req1_op = OP_AND; req1_num1 = 32'd3; req1_num2 = 32'd1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check("hold_req1_ready", 64'(req1_ready), 64'(0));
            check("hold_busy", 64'(busy), 64'(1));
            if (j >= 1) check("hold_resp0_result", 64'(resp0_result), 64'(32'hFF00_1200));
        end
        @(posedge clk); #1;
        resp0_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_req1_ready", 64'(req1_ready), 64'(1));
        @(posedge clk); #1;
        req1_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        // Invalid op code passes through.
        issue(1'b0, OP_BAD, 32'd123, 32'd456);
        @(negedge clk); @(negedge clk);
        check("bad_resp0_invalid", 64'(resp0_invalid), 64'(1));
        check("bad_resp0_result", 64'(resp0_result), 64'(0));
        @(posedge clk); #1;

        // Reset during HOLD.
        resp0_ready = 1'b0;
        issue(1'b0, OP_ADD, 32'd1, 32'd2);
        @(negedge clk); @(negedge clk);
        check("pre_rst_resp0_valid", 64'(resp0_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_resp_valid", 64'({resp1_valid, resp0_valid}), 64'(0));
        check("async_rst_busy", 64'(busy), 64'(0));
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = OP_OR;  req0_num1 = 32'h00F0; req0_num2 = 32'h0F00;
        req1_valid = 1'b1; req1_op = OP_SUB; req1_num1 = 32'd1;    req1_num2 = 32'd2;
        @(negedge clk);
        check("post_rst_tie_ready", 64'({req1_ready, req0_ready}), 64'(2'b01));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req1_ready) done = 1'b1;
            @(posedge clk); #1;
            if (done) break;
        end
        req1_valid = 1'b0;
        check("post_rst_req1_served", 64'(done), 64'(1));

        // Randomised traffic with random response back-pressure.
        for (int n = 0; n < 3000; n++) begin
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1'b1; req0_op = rand_op();
                req0_num1 = rand_opnd(); req0_num2 = rand_opnd();
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1'b1; req1_op = rand_op();
                req1_num1 = rand_opnd(); req1_num2 = rand_opnd();
            end
            resp0_ready = ($urandom_range(0, 3) != 0);
            resp1_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            hs0 = req0_valid && req0_ready;
            hs1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (hs0) req0_valid = 1'b0;
            if (hs1) req1_valid = 1'b0;
        end

        // Drain: every accepted operation must have produced its response.
        req0_valid = 1'b0; req1_valid = 1'b0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        @(negedge clk);
        check("drain_q0_empty", 64'(q0.size()), 64'(0));
        check("drain_q1_empty", 64'(q1.size()), 64'(0));
        check("drain_busy", 64'(busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
